mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 85 ++++++++
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles every bus signal of the scratch-pad memory arbiter:
//            the CPU-enable control, three requester ports (if, mem, test),
//            the two CPU stall flags and the SPM-side access port.
// Modports : slave  - arbiter side (takes requests, drives grants/SPM)
//            master - requester/SPM side (drives requests and read data)
// Ports    : per requester x in {if, mem, test}:
//              x_req, x_addr[ADDR_W], x_rw (1=read), x_wr_data[DATA_W]  -> arbiter
//              x_gnt, x_rd_valid, x_rd_data[DATA_W]                     <- arbiter
//            cpu_en                                                      -> arbiter
//            if_stall, mem_stall                                         <- arbiter
//            spm_addr, spm_as_ (active low), spm_rw, spm_wr_data         <- arbiter
//            spm_rd_data (valid the cycle after the strobe)              -> arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              cpu_en;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rw;
  logic [DATA_W-1:0] if_wr_data;
  logic              if_gnt;
  logic              if_rd_valid;
  logic [DATA_W-1:0] if_rd_data;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_gnt;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  logic              test_req;
  logic [ADDR_W-1:0] test_addr;
  logic              test_rw;
  logic [DATA_W-1:0] test_wr_data;
  logic              test_gnt;
  logic              test_rd_valid;
  logic [DATA_W-1:0] test_rd_data;

  logic              if_stall;
  logic              mem_stall;

  logic [ADDR_W-1:0] spm_addr;
  logic              spm_as_;
  logic              spm_rw;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;

  modport slave (
    input  cpu_en,
    input  if_req,   if_addr,   if_rw,   if_wr_data,
    output if_gnt,   if_rd_valid,   if_rd_data,
    input  mem_req,  mem_addr,  mem_rw,  mem_wr_data,
    output mem_gnt,  mem_rd_valid,  mem_rd_data,
    input  test_req, test_addr, test_rw, test_wr_data,
    output test_gnt, test_rd_valid, test_rd_data,
    output if_stall, mem_stall,
    output spm_addr, spm_as_, spm_rw, spm_wr_data,
    input  spm_rd_data
  );

  modport master (
    output cpu_en,
    output if_req,   if_addr,   if_rw,   if_wr_data,
    input  if_gnt,   if_rd_valid,   if_rd_data,
    output mem_req,  mem_addr,  mem_rw,  mem_wr_data,
    input  mem_gnt,  mem_rd_valid,  mem_rd_data,
    output test_req, test_addr, test_rw, test_wr_data,
    input  test_gnt, test_rd_valid, test_rd_data,
    input  if_stall, mem_stall,
    input  spm_addr, spm_as_, spm_rw, spm_wr_data,
    output spm_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port scratch-pad memory arbiter for three requesters
//            (instruction fetch "if", data "mem", and a "test" port).
//            One SPM access per cycle; a winning request is latched at a
//            clock edge and issued (strobe + grant) in the following cycle.
//            Read data returns one cycle after the strobe and is steered to
//            the requester recorded in a registered read tag.
// Ports    : clk         - clock
//            reset       - synchronous reset, active high
//            bus (slave) - mem_arbiter_if: cpu_en, requester ports,
//                          stall flags and SPM access port
// Params   : ADDR_W (word address width, default 30)
//            DATA_W (data width, default 32)
// Config   : MEM_ARB_RR_EN - when defined, if/mem are arbitrated round-robin
//            (pointer resets to favour mem); otherwise fixed priority mem > if.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mem_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_IF   = 2'd1;
  localparam logic [1:0] ID_MEM  = 2'd2;
  localparam logic [1:0] ID_TEST = 2'd3;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;

  logic [1:0]        r_owner;      // requester of the access being issued
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wr_data;
  logic [1:0]        r_rd_tag;     // owner of the read whose data returns now

  logic              w_if_gnt;
  logic              w_mem_gnt;
  logic              w_test_gnt;

  logic              w_if_elig;
  logic              w_mem_elig;
  logic              w_test_elig;
  logic              w_pick_if;

  logic [1:0]        w_win;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_win_rw;
  logic [DATA_W-1:0] w_win_wr_data;

  // --------------------------------------------------------------------------
  // Eligibility. A requester is masked in its own grant cycle: it is still
  // holding req (it has only just seen gnt), and re-arbitrating it here would
  // issue the same transaction twice. This also enforces the two-cycle
  // minimum spacing between grants to the same requester.
  // --------------------------------------------------------------------------
  assign w_if_elig   = bus.if_req   &  bus.cpu_en & ~w_if_gnt;
  assign w_mem_elig  = bus.mem_req  &  bus.cpu_en & ~w_mem_gnt;
  assign w_test_elig = bus.test_req & ~bus.cpu_en & ~w_test_gnt;

`ifdef MEM_ARB_RR_EN
  // 1 = mem received the most recent CPU grant, so if is favoured next.
  // Reset value 0 makes mem the favoured requester out of reset.
  logic r_rr_last_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last_mem <= 1'b0;
    end else if (w_mem_gnt) begin
      r_rr_last_mem <= 1'b1;
    end else if (w_if_gnt) begin
      r_rr_last_mem <= 1'b0;
    end
  end

  assign w_pick_if = w_if_elig & (~w_mem_elig | r_rr_last_mem);
`else
  // Fixed priority: if only wins when mem is not eligible.
  assign w_pick_if = w_if_elig & ~w_mem_elig;
`endif

  // --------------------------------------------------------------------------
  // Winner selection. test is only eligible while cpu_en=0 and if/mem only
  // while cpu_en=1, so test never competes with the CPU requesters.
  // --------------------------------------------------------------------------
  always_comb begin
    w_win         = ID_NONE;
    w_win_addr    = r_addr;
    w_win_rw      = r_rw;
    w_win_wr_data = r_wr_data;
    if (w_test_elig) begin
      w_win         = ID_TEST;
      w_win_addr    = bus.test_addr;
      w_win_rw      = bus.test_rw;
      w_win_wr_data = bus.test_wr_data;
    end else if (w_pick_if) begin
      w_win         = ID_IF;
      w_win_addr    = bus.if_addr;
      w_win_rw      = bus.if_rw;
      w_win_wr_data = bus.if_wr_data;
    end else if (w_mem_elig) begin
      w_win         = ID_MEM;
      w_win_addr    = bus.mem_addr;
      w_win_rw      = bus.mem_rw;
      w_win_wr_data = bus.mem_wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Arbitration is identical from either state; an access
  // is issued in the cycle after any eligible request is seen.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_win != ID_NONE) begin
      w_state_nxt = S_ACCESS;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (grant decode)
  // --------------------------------------------------------------------------
  always_comb begin
    w_if_gnt   = 1'b0;
    w_mem_gnt  = 1'b0;
    w_test_gnt = 1'b0;
    if (r_state == S_ACCESS) begin
      case (r_owner)
        ID_IF:   w_if_gnt   = 1'b1;
        ID_MEM:  w_mem_gnt  = 1'b1;
        ID_TEST: w_test_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Access latch and read tag. The latched fields only change when a new
  // access is won, so the SPM address/rw/data hold their last values in
  // IDLE. The read tag is taken from the access being issued this cycle,
  // independent of whatever is won at the same edge, so returning data is
  // steered correctly under back-to-back accesses and cpu_en changes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= ID_NONE;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_wr_data <= '0;
      r_rd_tag  <= ID_NONE;
    end else begin
      if (w_win != ID_NONE) begin
        r_owner   <= w_win;
        r_addr    <= w_win_addr;
        r_rw      <= w_win_rw;
        r_wr_data <= w_win_wr_data;
      end
      if ((r_state == S_ACCESS) && r_rw) begin
        r_rd_tag <= r_owner;
      end else begin
        r_rd_tag <= ID_NONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.if_gnt        = w_if_gnt;
  assign bus.mem_gnt       = w_mem_gnt;
  assign bus.test_gnt      = w_test_gnt;

  assign bus.if_rd_valid   = (r_rd_tag == ID_IF);
  assign bus.mem_rd_valid  = (r_rd_tag == ID_MEM);
  assign bus.test_rd_valid = (r_rd_tag == ID_TEST);

  assign bus.if_rd_data    = bus.spm_rd_data;
  assign bus.mem_rd_data   = bus.spm_rd_data;
  assign bus.test_rd_data  = bus.spm_rd_data;

  assign bus.if_stall      = bus.if_req  & ~w_if_gnt  & bus.cpu_en;
  assign bus.mem_stall     = bus.mem_req & ~w_mem_gnt & bus.cpu_en;

  assign bus.spm_as_       = (r_state != S_ACCESS);
  assign bus.spm_addr      = r_addr;
  assign bus.spm_rw        = r_rw;
  assign bus.spm_wr_data   = r_wr_data;

endmodule
`default_nettype wire
